// File: rtl/note_sequencer.sv
// ---------------------------------------------------------------------------
// note_sequencer
//   Record/playback controller between the switch-to-note encoder and the
//   tone generator.
//   - IDLE   : live note code is passed through with one cycle of latency.
//   - RECORD : the live note is sampled once per beat into a DEPTH-slot RAM.
//   - PLAY   : stored notes are replayed, each held for one full beat.
//   Rests (NOTE_NONE) are ordinary entries.
//
// Ports
//   CLK       in   system clock
//   RESET     in   synchronous, active-high reset
//   note_in   in   live 4-bit note code from encoder
//   rec_btn   in   start record (1-cycle pulse)
//   play_btn  in   start playback (1-cycle pulse)
//   stop_btn  in   abort record/playback (1-cycle pulse)
//   note_out  out  registered note code to tone generator
//   mode      out  00 IDLE, 01 RECORD, 10 PLAY
//   len       out  number of recorded slots, 0..DEPTH
//   ptr       out  current slot index
//
// Configuration
//   LOOP_PLAYBACK_EN : when defined, playback restarts at slot 0 after the
//                      last slot instead of returning to IDLE.
// ---------------------------------------------------------------------------
module note_sequencer #(
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned ADDR_W    = 4,
   parameter int unsigned BEAT_DIV  = 25_000_000,
   parameter logic [3:0]  NOTE_NONE = 4'd0
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [3:0]        note_in,
   input  logic              rec_btn,
   input  logic              play_btn,
   input  logic              stop_btn,
   output logic [3:0]        note_out,
   output logic [1:0]        mode,
   output logic [ADDR_W:0]   len,
   output logic [ADDR_W-1:0] ptr
);

   localparam int unsigned      CNT_W     = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
   localparam int unsigned      LEN_W     = ADDR_W + 1;
   localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(BEAT_DIV - 1);
   localparam logic [LEN_W-1:0] LEN_LAST  = LEN_W'(DEPTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_REC  = 2'b01,
      S_PLAY = 2'b10
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q,   cnt_d;
   logic [3:0]        note_q,  note_d;
   logic [LEN_W-1:0]  len_q,   len_d;
   logic [ADDR_W-1:0] ptr_q,   ptr_d;

   logic [3:0]        mem_q [DEPTH];
   logic              mem_we;

   logic              beat;
   logic [ADDR_W-1:0] ptr_inc;
   logic              more_slots;

   assign beat       = (state_q != S_IDLE) && (cnt_q == BEAT_LAST);
   assign ptr_inc    = ptr_q + ADDR_W'(1);
   // True while the current slot is not the last recorded one.
   assign more_slots = ({1'b0, ptr_q} + LEN_W'(1)) < len_q;

   always_comb begin
      state_d = state_q;
      note_d  = note_q;
      len_d   = len_q;
      ptr_d   = ptr_q;
      mem_we  = 1'b0;

      if (state_q == S_IDLE || beat) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      unique case (state_q)
         S_IDLE: begin
            note_d = note_in;
            // stop has top priority even though it does nothing here: a
            // simultaneous rec/play is swallowed.
            if (!stop_btn) begin
               if (rec_btn) begin
                  state_d = S_REC;
                  len_d   = '0;
                  ptr_d   = '0;
               end else if (play_btn && (len_q != '0)) begin
                  state_d = S_PLAY;
                  ptr_d   = '0;
                  note_d  = mem_q[0];
               end
            end
         end

         S_REC: begin
            note_d = note_in;
            if (stop_btn) begin
               state_d = S_IDLE;
            end else if (beat) begin
               mem_we = 1'b1;
               ptr_d  = ptr_inc;
               len_d  = len_q + LEN_W'(1);
               if (len_q == LEN_LAST) begin
                  state_d = S_IDLE;
               end
            end
         end

         S_PLAY: begin
            if (stop_btn) begin
               state_d = S_IDLE;
               note_d  = note_in;
            end else if (beat) begin
               if (more_slots) begin
                  ptr_d  = ptr_inc;
                  note_d = mem_q[ptr_inc];
               end else begin
                  ptr_d = '0;
`ifdef LOOP_PLAYBACK_EN
                  note_d  = mem_q[0];
`else
                  state_d = S_IDLE;
                  note_d  = note_in;
`endif
               end
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Every mode change restarts the beat timing from zero.
      if (state_d != state_q) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         note_q  <= NOTE_NONE;
         len_q   <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         note_q  <= note_d;
         len_q   <= len_d;
         ptr_q   <= ptr_d;
      end
   end

   // Note RAM: synchronous write, asynchronous read, never cleared.
   always_ff @(posedge CLK) begin
      if (mem_we && !RESET) begin
         mem_q[ptr_q] <= note_in;
      end
   end

   assign note_out = note_q;
   assign mode     = state_q;
   assign len      = len_q;
   assign ptr      = ptr_q;

endmodule

// File: tb/tb_note_sequencer.sv
// ---------------------------------------------------------------------------
// tb_note_sequencer
//   Self-checking bench for note_sequencer with BEAT_DIV=4: a table of
//   single-cycle vectors, hand-written multi-cycle sequences and a random
//   phase, all cross-checked every cycle against a song-level reference model.
// ---------------------------------------------------------------------------
module tb_note_sequencer;

   localparam int DEPTH    = 16;
   localparam int ADDR_W   = 4;
   localparam int BEAT_DIV = 4;

   logic                CLK = 1'b0;
   logic                RESET;
   logic [3:0]          note_in;
   logic                rec_btn, play_btn, stop_btn;
   logic [3:0]          note_out;
   logic [1:0]          mode;
   logic [ADDR_W:0]     len;
   logic [ADDR_W-1:0]   ptr;

   note_sequencer #(
      .DEPTH    (DEPTH),
      .ADDR_W   (ADDR_W),
      .BEAT_DIV (BEAT_DIV),
      .NOTE_NONE(4'd0)
   ) dut (
      .CLK     (CLK),
      .RESET   (RESET),
      .note_in (note_in),
      .rec_btn (rec_btn),
      .play_btn(play_btn),
      .stop_btn(stop_btn),
      .note_out(note_out),
      .mode    (mode),
      .len     (len),
      .ptr     (ptr)
   );

   always #5 CLK = ~CLK;

   int n_cmp = 0;
   int n_err = 0;

   function automatic void chk(input string name, input logic [31:0] got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0d required %0d", name, $time, got, exp);
      end
   endfunction

   // ---------------- reference model (song level) ----------------
   // mode: 0 idle, 1 record, 2 play. phase = cycles spent in current mode.
   int m_mode, m_len, m_ptr, m_phase, m_note;
   int m_song[DEPTH];

   task automatic model_step(input bit r, input int n, input bit rc, input bit pl, input bit st);
      bit on_beat;
      if (r) begin
         m_mode = 0; m_note = 0; m_len = 0; m_ptr = 0; m_phase = 0;
         return;
      end
      on_beat = (m_mode != 0) && ((m_phase % BEAT_DIV) == BEAT_DIV - 1);
      m_phase++;
      case (m_mode)
         0: begin
            m_note = n;
            if (!st) begin
               if (rc) begin
                  m_mode = 1; m_len = 0; m_ptr = 0; m_phase = 0;
               end else if (pl && m_len > 0) begin
                  m_mode = 2; m_ptr = 0; m_phase = 0; m_note = m_song[0];
               end
            end
         end
         1: begin
            m_note = n;
            if (st) m_mode = 0;
            else if (on_beat) begin
               m_song[m_ptr] = n;
               m_ptr = (m_ptr + 1) % DEPTH;
               m_len++;
               if (m_len == DEPTH) m_mode = 0;
            end
         end
         default: begin
            if (st) begin
               m_mode = 0; m_note = n;
            end else if (on_beat) begin
               if (m_ptr + 1 < m_len) begin
                  m_ptr++;
                  m_note = m_song[m_ptr];
               end else begin
                  m_ptr = 0;
`ifdef LOOP_PLAYBACK_EN
                  m_note = m_song[0];
`else
                  m_mode = 0; m_note = n;
`endif
               end
            end
         end
      endcase
      if (m_mode == 0) m_phase = 0;
   endtask

   // One clock: drive inputs, advance model, sample #1 after the edge.
   task automatic cyc(input bit r, input int n, input bit rc, input bit pl, input bit st);
      RESET = r; note_in = 4'(n); rec_btn = rc; play_btn = pl; stop_btn = st;
      model_step(r, n, rc, pl, st);
      @(posedge CLK);
      #1;
      chk("model_note", 32'(note_out), m_note);
      chk("model_mode", 32'(mode),     m_mode);
      chk("model_len",  32'(len),      m_len);
      chk("model_ptr",  32'(ptr),      m_ptr);
      RESET = 1'b0; rec_btn = 1'b0; play_btn = 1'b0; stop_btn = 1'b0;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      bit rst; int note; bit rec; bit play; bit stop;
      int e_note; int e_mode; int e_len; int e_ptr;
   } vec_t;

   function automatic vec_t mk(input bit r, input int n, input bit rc, input bit pl, input bit st,
                               input int en, input int em, input int el, input int ep);
      vec_t v;
      v.rst = r; v.note = n; v.rec = rc; v.play = pl; v.stop = st;
      v.e_note = en; v.e_mode = em; v.e_len = el; v.e_ptr = ep;
      return v;
   endfunction

   localparam int NV = 20;
   vec_t vt[NV];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      RESET = 1'b0; note_in = '0; rec_btn = 1'b0; play_btn = 1'b0; stop_btn = 1'b0;

      //            rst note rec ply stp | note mode len ptr
      vt[0]  = mk(1, 5, 0, 0, 0,  0, 0, 0, 0);
      vt[1]  = mk(1, 5, 0, 0, 0,  0, 0, 0, 0);
      vt[2]  = mk(0, 5, 0, 0, 0,  5, 0, 0, 0);
      vt[3]  = mk(0, 9, 0, 0, 0,  9, 0, 0, 0);
      vt[4]  = mk(0, 2, 0, 1, 0,  2, 0, 0, 0);   // play with empty song ignored
      vt[5]  = mk(0, 4, 1, 0, 1,  4, 0, 0, 0);   // stop+rec: stop wins
      vt[6]  = mk(0, 6, 1, 0, 0,  6, 1, 0, 0);
      vt[7]  = mk(0, 1, 0, 0, 0,  1, 1, 0, 0);
      vt[8]  = mk(0, 1, 0, 0, 0,  1, 1, 0, 0);
      vt[9]  = mk(0, 1, 0, 0, 0,  1, 1, 0, 0);
      vt[10] = mk(0, 1, 0, 0, 0,  1, 1, 1, 1);   // beat 1 writes 1
      vt[11] = mk(0, 3, 0, 0, 0,  3, 1, 1, 1);
      vt[12] = mk(0, 3, 0, 0, 0,  3, 1, 1, 1);
      vt[13] = mk(0, 3, 0, 0, 0,  3, 1, 1, 1);
      vt[14] = mk(0, 3, 0, 0, 0,  3, 1, 2, 2);   // beat 2 writes 3
      vt[15] = mk(0, 0, 0, 0, 0,  0, 1, 2, 2);
      vt[16] = mk(0, 0, 0, 0, 0,  0, 1, 2, 2);
      vt[17] = mk(0, 0, 0, 0, 0,  0, 1, 2, 2);
      vt[18] = mk(0, 0, 0, 0, 0,  0, 1, 3, 3);   // beat 3 writes rest
      vt[19] = mk(0, 8, 0, 0, 1,  8, 0, 3, 3);   // stop keeps len

      for (int i = 0; i < NV; i++) begin
         cyc(vt[i].rst, vt[i].note, vt[i].rec, vt[i].play, vt[i].stop);
         chk($sformatf("tbl%0d_note", i), 32'(note_out), vt[i].e_note);
         chk($sformatf("tbl%0d_mode", i), 32'(mode),     vt[i].e_mode);
         chk($sformatf("tbl%0d_len", i),  32'(len),      vt[i].e_len);
         chk($sformatf("tbl%0d_ptr", i),  32'(ptr),      vt[i].e_ptr);
      end

      // ---------------- playback of {1,3,0} ----------------
      cyc(0, 8, 0, 1, 0);
      chk("play_enter_mode", 32'(mode), 2);
      chk("play_enter_note", 32'(note_out), 1);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 8, 0, 0, 0);
         chk("play_slot0", 32'(note_out), 1);
      end
      for (int i = 0; i < 4; i++) begin
         cyc(0, 8, 0, 0, 0);
         chk("play_slot1", 32'(note_out), 3);
      end
      for (int i = 0; i < 4; i++) begin
         cyc(0, 8, 0, 0, 0);
         chk("play_slot2", 32'(note_out), 0);
      end
      cyc(0, 8, 0, 0, 0);
`ifdef LOOP_PLAYBACK_EN
      chk("end_mode", 32'(mode), 2);
      chk("end_note", 32'(note_out), 1);
`else
      chk("end_mode", 32'(mode), 0);
      chk("end_note", 32'(note_out), 8);
      cyc(0, 8, 0, 1, 0);
      chk("replay_mode", 32'(mode), 2);
`endif
      chk("end_ptr", 32'(ptr), 0);
      chk("end_len", 32'(len), 3);
      cyc(0, 8, 0, 0, 0);
      cyc(1, 8, 0, 0, 0);            // reset mid-play
      chk("rstplay_mode", 32'(mode), 0);
      chk("rstplay_len",  32'(len), 0);
      chk("rstplay_note", 32'(note_out), 0);
      cyc(0, 5, 0, 0, 0);
      chk("after_rst_note", 32'(note_out), 5);

      // ---------------- stop on beat cycle in RECORD ----------------
      cyc(0, 7, 1, 0, 0);
      for (int i = 0; i < 3; i++) cyc(0, 7, 0, 0, 0);
      cyc(0, 9, 0, 0, 1);
      chk("stopbeat_len",  32'(len), 0);
      chk("stopbeat_mode", 32'(mode), 0);
      chk("stopbeat_ptr",  32'(ptr), 0);

      // ---------------- full 16-beat recording ----------------
      cyc(0, 7, 1, 0, 0);
      for (int i = 0; i < 63; i++) cyc(0, 7, 0, 0, 0);
      chk("full15_len",  32'(len), 15);
      chk("full15_mode", 32'(mode), 1);
      cyc(0, 7, 0, 0, 0);
      chk("full16_len",  32'(len), 16);
      chk("full16_mode", 32'(mode), 0);
      chk("full16_ptr",  32'(ptr), 0);
      for (int i = 0; i < 8; i++) cyc(0, 2, 0, 0, 0);
      chk("full_after_len",  32'(len), 16);
      chk("full_after_note", 32'(note_out), 2);

      // ---------------- randomized phase ----------------
      for (int i = 0; i < 3000; i++) begin
         cyc($urandom_range(0, 399) == 0,
             int'($urandom_range(0, 15)),
             $urandom_range(0, 59) == 0,
             $urandom_range(0, 39) == 0,
             $urandom_range(0, 149) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
